// File: rtl/count_display_scan.sv
// count_display_scan: keeps a 4-deep history of counter values and scans it onto a 4-digit seven-segment display
module count_display_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic [3:0] count_in,
    input  logic       count_valid,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       new_flag
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [3:0]    d [4];
    logic [2:0]    fill;
    logic          wrap;
    logic [PW-1:0] presc;
    logic [1:0]    ptr;
    logic          capture;
    logic          tick;
    logic          blank;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n;

    function automatic logic [6:0] hex(input logic [3:0] v);
        case (v)
            4'h0: hex = 7'b1000000;
            4'h1: hex = 7'b1111001;
            4'h2: hex = 7'b0100100;
            4'h3: hex = 7'b0110000;
            4'h4: hex = 7'b0011001;
            4'h5: hex = 7'b0010010;
            4'h6: hex = 7'b0000010;
            4'h7: hex = 7'b1111000;
            4'h8: hex = 7'b0000000;
            4'h9: hex = 7'b0010000;
            4'ha: hex = 7'b0001000;
            4'hb: hex = 7'b0000011;
            4'hc: hex = 7'b1000110;
            4'hd: hex = 7'b0100001;
            4'he: hex = 7'b0000110;
            default: hex = 7'b0001110;
        endcase
    endfunction

    // capture qualification, scan tick and the display image for the current digit
    always_comb begin
        capture = count_valid && (fill == 3'd0 || count_in != d[0]);
        tick    = presc == PW'(REFRESH_DIV - 1);
        blank   = {1'b0, ptr} >= fill;
        an_n    = blank ? 4'b1111 : ~(4'b0001 << ptr);
        seg_n   = blank ? 7'b1111111 : hex(d[ptr]);
        dp_n    = ~(!blank && ptr == 2'd0 && wrap);
    end

    // history shift, fill level and wrap flag, updated only on a fresh value
    always_ff @(posedge clk1) begin
        if (rst) begin
            d    <= '{default: 4'd0};
            fill <= 3'd0;
            wrap <= 1'b0;
        end else if (capture) begin
            d    <= '{count_in, d[0], d[1], d[2]};
            fill <= (fill == 3'd4) ? fill : fill + 3'd1;
            wrap <= fill != 3'd0 && count_in < d[0];
        end
    end

    // dwell prescaler advancing the digit pointer on its terminal count
    always_ff @(posedge clk1) begin
        if (rst) begin
            presc <= '0;
            ptr   <= 2'd0;
        end else if (tick) begin
            presc <= '0;
            ptr   <= ptr + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // registered pins so no input reaches an output combinationally
    always_ff @(posedge clk1) begin
        if (rst) begin
            an       <= 4'b1111;
            seg      <= 7'b1111111;
            dp       <= 1'b1;
            new_flag <= 1'b0;
        end else begin
            an       <= an_n;
            seg      <= seg_n;
            dp       <= dp_n;
            new_flag <= capture;
        end
    end
endmodule
